fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch front end of the RV32I core. Owns the fetch PC, issues
//  in-order word requests to instruction memory and buffers the returned
//  instructions in a DEPTH-entry FIFO for decode. Decode takes instr[31:7]
//  for immediate extension and instr[6:0]/funct fields for control.
//  Branch and jal targets (PC + extended immediate) come back as a redirect
//  that flushes the queue and any in-flight fetches.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset; bits [1:0] must be 0
//  DEPTH     2              queue entries; power of two, >= 2
// PORTS
//  clk             in   1   single clock, rising edge
//  reset_n         in   1   synchronous, active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_rsp_valid  in   1   response data valid (in order, >=1 cycle after accept)
//  imem_rsp_data   in   32  returned instruction word
//  redirect_valid  in   1   taken branch/jal; flush and refetch
//  redirect_pc     in   32  new fetch address; bits [1:0] ignored (forced 0)
//  instr_valid     out  1   queue head valid
//  instr_ready     in   1   decode consumes head this cycle
//  instr           out  32  head instruction; 32'h0000_0013 (addi x0,x0,0) when empty
//  instr_pc        out  32  PC of head instruction; 0 when empty
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): fetch_pc=RESET_PC, queue empty, outstanding=0,
//    drop=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0,
//    instr=32'h0000_0013, instr_pc=0. Reset mid-burst discards everything,
//    including responses to pre-reset requests arriving after release.
//  - Credit rule: imem_req_valid=1 iff reset_n=1 and (count + outstanding) < DEPTH
//    and redirect_valid=0. The queue can therefore never overflow; every
//    accepted response has a slot.
//  - Request accepted (valid&ready): outstanding+1; fetch_pc += 4 (wraps mod 2^32).
//    imem_req_addr = fetch_pc at all times.
//  - Response: outstanding-1. If drop>0: drop-1, data discarded. Else word and its
//    PC (tracked by rsp_pc, which also +4 per kept response) are written to the tail.
//    Response with outstanding=0 is a protocol error: ignored, counters unchanged.
//  - Latency: request accepted cycle t, response earliest t+1, instr_valid at t+2.
//  - Dequeue on instr_valid&instr_ready. Simultaneous enqueue/dequeue keeps count.
//    Full: no new requests. Empty: instr_valid=0, NOP on instr.
//  - Redirect (priority over all else in that cycle): queue flushed (count=0),
//    fetch_pc=rsp_pc={redirect_pc[31:2],2'b00}, drop = outstanding after this
//    cycle's accept/response updates (a response arriving in the redirect cycle is
//    itself dropped; no request is issued in the redirect cycle). First new request
//    issues at t+1; new instr_valid earliest t+3.
//  - Back-to-back redirects: last one wins; drop accumulates all older in-flight
//    fetches.
//  - Counter widths: outstanding/drop/count are $clog2(DEPTH)+1 bits, never exceed DEPTH.
// TESTING
//  1. Reset release, ready=1, rsp 1 cycle later: addrs 0x0,0x4 issued, queue fills,
//     no 3rd req until decode pops; instr_pc 0x0 then 0x4.
//  2. instr_ready=0 for 10 cycles: exactly DEPTH requests, instr holds
//     word@0x0, no overflow.
//  3. Redirect to 0x0000_0103 with 2 fetches outstanding: both responses dropped,
//     next req addr 0x0000_0100, first instr_pc 0x100.
//  4. Redirect in same cycle as response and decode pop: response dropped,
//     instr_valid=0 next cycle.
//  5. fetch_pc=0xFFFF_FFFC: next request addr 0x0000_0000.
//  6. reset_n=0 for one cycle with 2 outstanding: late responses ignored,
//     first instr_pc after release = RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: RV32I instruction fetch front end.
// Owns the fetch PC, issues in-order word requests to instruction memory
// under a credit limit, and buffers returned words (with their PCs) in a
// DEPTH-entry FIFO for decode. A redirect flushes the FIFO and marks every
// in-flight fetch to be discarded when its response comes back.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int          CW  = $clog2(DEPTH) + 1;
    localparam int          AW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic [CW:0]   inflight;
    logic          accept;
    logic          rsp_ok;
    logic          rsp_keep;
    logic          pop;
    logic [CW-1:0] out_next;
    logic [31:0]   redirect_tgt;

    // Credit check, handshakes and next outstanding count.
    // Every queued entry plus every in-flight fetch (dropped or not) holds a
    // credit, so an accepted response always has a free slot.
    always_comb begin
        inflight       = {1'b0, count} + {1'b0, outstanding};
        imem_req_valid = reset_n && (inflight < (CW+1)'(DEPTH)) && !redirect_valid;
        imem_req_addr  = fetch_pc;
        accept         = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored;
        // this also discards late responses to requests issued before a reset.
        rsp_ok         = imem_rsp_valid && (outstanding != '0);
        rsp_keep       = rsp_ok && (drop == '0) && !redirect_valid;
        instr_valid    = (count != '0);
        pop            = instr_valid && instr_ready && !redirect_valid;
        out_next       = outstanding + CW'(accept) - CW'(rsp_ok);
        // Masking keeps every redirect_pc bit in use while forcing word alignment.
        redirect_tgt   = redirect_pc & 32'hFFFF_FFFC;
        instr          = instr_valid ? data_q[head] : NOP;
        instr_pc       = instr_valid ? pc_q[head]   : 32'h0;
    end

    // Control state: PCs, counters, FIFO pointers; redirect overrides everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_tgt;
                rsp_pc   <= redirect_tgt;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                drop     <= out_next;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp_ok && (drop != '0))
                    drop <= drop - CW'(1);
                if (rsp_keep) begin
                    tail   <= tail + AW'(1);
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop)
                    head <= head + AW'(1);
                count <= count + CW'(rsp_keep) - CW'(pop);
            end
        end
    end

    // FIFO storage: no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (reset_n && rsp_keep) begin
            data_q[tail] <= imem_rsp_data;
            pc_q[tail]   <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed, table-driven checks of fetch_queue (DEPTH=2).
// Each vector drives one cycle of inputs and lists the outputs expected in
// that cycle; inputs change on the falling edge and outputs are sampled 1ns later.
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        redir;
        logic [31:0] rpc;
        logic        ir;
        logic        qv;
        logic [31:0] qa;
        logic        iv;
        logic [31:0] ins;
        logic [31:0] ipc;
        int          rep;
    } vec_t;

    function automatic vec_t mk(input logic rst_n, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic redir,
                                input logic [31:0] rpc, input logic ir,
                                input logic qv, input logic [31:0] qa, input logic iv,
                                input logic [31:0] ins, input logic [31:0] ipc,
                                input int rep);
        vec_t v;
        v.rst_n = rst_n; v.rdy = rdy; v.rv = rv; v.rd = rd; v.redir = redir;
        v.rpc = rpc; v.ir = ir; v.qv = qv; v.qa = qa; v.iv = iv; v.ins = ins;
        v.ipc = ipc; v.rep = rep;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    // Drive one vector for v.rep cycles, checking outputs in each cycle.
    task automatic apply(input int row, input vec_t v);
        for (int k = 0; k < v.rep; k++) begin
            @(negedge clk);
            reset_n        = v.rst_n;
            imem_req_ready = v.rdy;
            imem_rsp_valid = v.rv;
            imem_rsp_data  = v.rd;
            redirect_valid = v.redir;
            redirect_pc    = v.rpc;
            instr_ready    = v.ir;
            #1;
            chk("req_valid",   row, {31'b0, imem_req_valid}, {31'b0, v.qv});
            chk("req_addr",    row, imem_req_addr, v.qa);
            chk("instr_valid", row, {31'b0, instr_valid}, {31'b0, v.iv});
            chk("instr",       row, instr, v.ins);
            chk("instr_pc",    row, instr_pc, v.ipc);
        end
    endtask

    localparam logic [31:0] W0  = 32'h1000_0001, W1  = 32'h1000_0002;
    localparam logic [31:0] W8  = 32'h1000_0008, W12 = 32'h1000_000C;
    localparam logic [31:0] WA  = 32'h2000_0013, WB  = 32'h2000_0093;
    localparam logic [31:0] WC  = 32'h3000_0001, WD  = 32'h3000_0002;
    localparam logic [31:0] WE  = 32'hDEAD_BEEF, WF  = 32'hBAD0_0001;
    localparam logic [31:0] WG  = 32'hBAD0_0002, X1  = 32'h4000_0001;
    localparam logic [31:0] X2  = 32'h4000_0002, WZ  = 32'h5000_0013;

    vec_t tbl[$];

    initial begin
        reset_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);

        //              rst rdy rv rd   rdr rpc            ir  qv qa             iv ins  ipc            rep
        tbl.push_back(mk(0, 0, 0, 0,   0, 0,             0,  0, 32'h0,         0, NOP, 32'h0,         1)); // reset state
        tbl.push_back(mk(1, 1, 0, 0,   0, 0,             0,  1, 32'h0,         0, NOP, 32'h0,         1)); // req @0
        tbl.push_back(mk(1, 1, 1, W0,  0, 0,             0,  1, 32'h4,         0, NOP, 32'h0,         1)); // req @4, rsp @0
        tbl.push_back(mk(1, 1, 1, W1,  0, 0,             0,  0, 32'h8,         1, W0,  32'h0,         1)); // credits exhausted
        tbl.push_back(mk(1, 1, 0, 0,   0, 0,             0,  0, 32'h8,         1, W0,  32'h0,        10)); // decode stalled
        tbl.push_back(mk(1, 1, 0, 0,   0, 0,             1,  0, 32'h8,         1, W0,  32'h0,         1)); // pop W0
        tbl.push_back(mk(1, 1, 0, 0,   0, 0,             0,  1, 32'h8,         1, W1,  32'h4,         1)); // req @8
        tbl.push_back(mk(1, 1, 0, 0,   0, 0,             1,  0, 32'hC,         1, W1,  32'h4,         1)); // pop W1
        tbl.push_back(mk(1, 1, 0, 0,   0, 0,             0,  1, 32'hC,         0, NOP, 32'h0,         1)); // req @C, 2 outstanding
        tbl.push_back(mk(1, 1, 0, 0,   1, 32'h103,       0,  0, 32'h10,        0, NOP, 32'h0,         1)); // redirect 0x103
        tbl.push_back(mk(1, 1, 1, W8,  0, 0,             0,  0, 32'h100,       0, NOP, 32'h0,         1)); // dropped rsp
        tbl.push_back(mk(1, 1, 1, W12, 0, 0,             0,  1, 32'h100,       0, NOP, 32'h0,         1)); // dropped rsp, req @100
        tbl.push_back(mk(1, 1, 1, WA,  0, 0,             0,  1, 32'h104,       0, NOP, 32'h0,         1)); // rsp @100 kept
        tbl.push_back(mk(1, 1, 1, WB,  1, 32'hFFFF_FFFC, 1,  0, 32'h108,       1, WA,  32'h100,       1)); // redirect+rsp+pop
        tbl.push_back(mk(1, 1, 0, 0,   0, 0,             0,  1, 32'hFFFF_FFFC, 0, NOP, 32'h0,         1)); // queue empty after
        tbl.push_back(mk(1, 1, 1, WC,  0, 0,             0,  1, 32'h0,         0, NOP, 32'h0,         1)); // pc wrap
        tbl.push_back(mk(1, 0, 1, WD,  0, 0,             0,  0, 32'h4,         1, WC,  32'hFFFF_FFFC, 1));
        tbl.push_back(mk(1, 0, 0, 0,   0, 0,             1,  0, 32'h4,         1, WC,  32'hFFFF_FFFC, 1));
        tbl.push_back(mk(1, 0, 0, 0,   0, 0,             1,  1, 32'h4,         1, WD,  32'h0,         1));
        tbl.push_back(mk(1, 0, 1, WE,  0, 0,             0,  1, 32'h4,         0, NOP, 32'h0,         1)); // stray rsp
        tbl.push_back(mk(1, 0, 0, 0,   0, 0,             0,  1, 32'h4,         0, NOP, 32'h0,         1)); // stray ignored
        tbl.push_back(mk(1, 1, 0, 0,   0, 0,             0,  1, 32'h4,         0, NOP, 32'h0,         1));
        tbl.push_back(mk(1, 1, 0, 0,   0, 0,             0,  1, 32'h8,         0, NOP, 32'h0,         1)); // 2 outstanding
        tbl.push_back(mk(0, 1, 0, 0,   0, 0,             0,  0, 32'hC,         0, NOP, 32'h0,         1)); // 1-cycle reset
        tbl.push_back(mk(1, 0, 1, WF,  0, 0,             0,  1, 32'h0,         0, NOP, 32'h0,         1)); // late rsp ignored
        tbl.push_back(mk(1, 1, 1, WG,  0, 0,             0,  1, 32'h0,         0, NOP, 32'h0,         1)); // late rsp, req @0
        tbl.push_back(mk(1, 0, 1, W0,  0, 0,             0,  1, 32'h4,         0, NOP, 32'h0,         1));
        tbl.push_back(mk(1, 0, 0, 0,   0, 0,             0,  1, 32'h4,         1, W0,  32'h0,         1));

        foreach (tbl[i]) apply(i, tbl[i]);

        // Back-to-back redirects with a fetch between: drop must cover both
        // older fetches, and only the response for the newest path is kept.
        apply(100, mk(1, 1, 0, 0,  0, 0,       0, 1, 32'h4,   1, W0,  32'h0,   1)); // req @4
        apply(101, mk(1, 1, 0, 0,  1, 32'h200, 0, 0, 32'h8,   1, W0,  32'h0,   1)); // redirect 0x200
        apply(102, mk(1, 1, 0, 0,  0, 0,       0, 1, 32'h200, 0, NOP, 32'h0,   1)); // req @200
        apply(103, mk(1, 1, 0, 0,  1, 32'h302, 0, 0, 32'h204, 0, NOP, 32'h0,   1)); // redirect 0x302
        apply(104, mk(1, 1, 1, X1, 0, 0,       0, 0, 32'h300, 0, NOP, 32'h0,   1)); // dropped
        apply(105, mk(1, 1, 1, X2, 0, 0,       0, 1, 32'h300, 0, NOP, 32'h0,   1)); // dropped, req @300
        apply(106, mk(1, 0, 1, WZ, 0, 0,       0, 1, 32'h304, 0, NOP, 32'h0,   1)); // kept
        apply(107, mk(1, 0, 0, 0,  0, 0,       0, 1, 32'h304, 1, WZ,  32'h300, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
